// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap controller: FSM state and
// event-kind encodings, mcause exception codes and the mcause interrupt
// bit position.
package trap_ctrl_pkg;

  localparam int TRAP_ST_WIDTH = 2;

  // mcause exception codes for synchronous exceptions
  localparam int CAUSE_ILLEGAL = 2;
  localparam int CAUSE_ECALL_M = 11;

  typedef enum logic [TRAP_ST_WIDTH-1:0] {
    TRAP_IDLE  = 2'd0,
    TRAP_TRAP  = 2'd1,
    TRAP_MRET  = 2'd2,
    TRAP_REDIR = 2'd3
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_IRQ  = 2'd1,
    KIND_MRET = 2'd2
  } trap_kind_e;

  // The interrupt flag of mcause is the MSB of the register
  function automatic int irq_bit_pos(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/trap_cause_enc.sv
// Combinational event selector for the trap controller. Picks the winning
// commit-point event (illegal > ecall > enabled irq > mret) and produces
// its kind, mcause value and mtval value. Nothing qualifies without
// commit_valid, so a pending interrupt always lands on a real PC.
module trap_cause_enc
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IRQ_CODE = 11
) (
  input  logic             commit_valid,
  input  logic [31:0]      commit_inst,
  input  logic             commit_illegal,
  input  logic             commit_ecall,
  input  logic             commit_mret,
  input  logic             irq_req,
  input  logic             csr_mie,
  output logic             evt_valid,
  output trap_kind_e       evt_kind,
  output logic [XLEN-1:0]  evt_cause,
  output logic [XLEN-1:0]  evt_tval
);

  localparam int              IRQ_BIT   = irq_bit_pos(XLEN);
  localparam logic [XLEN-1:0] IRQ_CAUSE = XLEN'(IRQ_CODE) | (XLEN'(1) << IRQ_BIT);

  // Priority selection of the commit-point event
  always_comb begin
    evt_valid = 1'b0;
    evt_kind  = KIND_EXC;
    evt_cause = '0;
    evt_tval  = '0;
    if (commit_valid && commit_illegal) begin
      evt_valid = 1'b1;
      evt_kind  = KIND_EXC;
      evt_cause = XLEN'(CAUSE_ILLEGAL);
      evt_tval  = XLEN'(commit_inst);
    end else if (commit_valid && commit_ecall) begin
      evt_valid = 1'b1;
      evt_kind  = KIND_EXC;
      evt_cause = XLEN'(CAUSE_ECALL_M);
    end else if (commit_valid && irq_req && csr_mie) begin
      evt_valid = 1'b1;
      evt_kind  = KIND_IRQ;
      evt_cause = IRQ_CAUSE;
    end else if (commit_valid && commit_mret) begin
      evt_valid = 1'b1;
      evt_kind  = KIND_MRET;
    end else begin
      evt_valid = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap responder for the pipelined RV32I core. Takes the commit-point
// event, then sequences flush, the machine-CSR trap/mret write strobe and
// the PC redirect (event at N, CSR strobe at N+1, redirect at N+2).
// All outputs come straight from flops.
// Optional build macro: TRAP_VECTORED_MTVEC_EN -- when defined, interrupts
// with mtvec mode 2'b01 redirect to base + (IRQ_CODE << 2).
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IRQ_CODE = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_valid,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [31:0]      commit_inst,
  input  logic             commit_illegal,
  input  logic             commit_ecall,
  input  logic             commit_mret,
  input  logic             irq_req,
  input  logic             csr_mie,
  input  logic [XLEN-1:0]  csr_mtvec,
  input  logic [XLEN-1:0]  csr_mepc,
  output logic             flush,
  output logic             stall,
  output logic             trap_we,
  output logic [XLEN-1:0]  mepc_wdata,
  output logic [XLEN-1:0]  mcause_wdata,
  output logic [XLEN-1:0]  mtval_wdata,
  output logic             mret_we,
  output logic             redirect_en,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             irq_ack
);

  trap_state_e      state_q, state_d;
  trap_kind_e       kind_q, kind_d;
  logic             flush_q, flush_d;
  logic             stall_q, stall_d;
  logic             trap_we_q, trap_we_d;
  logic             mret_we_q, mret_we_d;
  logic             redirect_en_q, redirect_en_d;
  logic             irq_ack_q, irq_ack_d;
  logic [XLEN-1:0]  mepc_q, mepc_d;
  logic [XLEN-1:0]  mcause_q, mcause_d;
  logic [XLEN-1:0]  mtval_q, mtval_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

  logic             evt_valid_s;
  trap_kind_e       evt_kind_s;
  logic [XLEN-1:0]  evt_cause_s;
  logic [XLEN-1:0]  evt_tval_s;
  logic [XLEN-1:0]  target_s;
  logic             unused_lsb_s;

  // Address LSBs are cleared on every redirect target
  assign unused_lsb_s = ^{csr_mepc[1:0], csr_mtvec[1:0]};

  trap_cause_enc #(
    .XLEN     (XLEN),
    .IRQ_CODE (IRQ_CODE)
  ) u_cause_enc (
    .commit_valid   (commit_valid),
    .commit_inst    (commit_inst),
    .commit_illegal (commit_illegal),
    .commit_ecall   (commit_ecall),
    .commit_mret    (commit_mret),
    .irq_req        (irq_req),
    .csr_mie        (csr_mie),
    .evt_valid      (evt_valid_s),
    .evt_kind       (evt_kind_s),
    .evt_cause      (evt_cause_s),
    .evt_tval       (evt_tval_s)
  );

  // Redirect target: mepc for mret, otherwise the (optionally vectored) mtvec base
  always_comb begin
    target_s = {csr_mtvec[XLEN-1:2], 2'b00};
    if (kind_q == KIND_MRET) begin
      target_s = {csr_mepc[XLEN-1:2], 2'b00};
    end else begin
`ifdef TRAP_VECTORED_MTVEC_EN
      if ((csr_mtvec[1:0] == 2'b01) && (kind_q == KIND_IRQ)) begin
        target_s = {csr_mtvec[XLEN-1:2], 2'b00} + (XLEN'(IRQ_CODE) << 2);
      end else begin
        target_s = {csr_mtvec[XLEN-1:2], 2'b00};
      end
`else
      target_s = {csr_mtvec[XLEN-1:2], 2'b00};
`endif
    end
  end

  // Next state and next-cycle output values; inputs only matter in IDLE
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    flush_d       = 1'b0;
    stall_d       = 1'b0;
    trap_we_d     = 1'b0;
    mret_we_d     = 1'b0;
    redirect_en_d = 1'b0;
    irq_ack_d     = 1'b0;
    mepc_d        = '0;
    mcause_d      = '0;
    mtval_d       = '0;
    redirect_pc_d = '0;
    case (state_q)
      TRAP_IDLE: begin
        if (evt_valid_s) begin
          kind_d  = evt_kind_s;
          flush_d = 1'b1;
          stall_d = 1'b1;
          if (evt_kind_s == KIND_MRET) begin
            state_d   = TRAP_MRET;
            mret_we_d = 1'b1;
          end else begin
            state_d   = TRAP_TRAP;
            trap_we_d = 1'b1;
            mepc_d    = commit_pc;
            mcause_d  = evt_cause_s;
            mtval_d   = evt_tval_s;
            irq_ack_d = (evt_kind_s == KIND_IRQ);
          end
        end else begin
          state_d = TRAP_IDLE;
        end
      end
      TRAP_TRAP, TRAP_MRET: begin
        state_d       = TRAP_REDIR;
        flush_d       = 1'b1;
        redirect_en_d = 1'b1;
        redirect_pc_d = target_s;
      end
      TRAP_REDIR: begin
        state_d = TRAP_IDLE;
      end
      default: begin
        state_d = TRAP_IDLE;
      end
    endcase
  end

  // State, latched kind and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TRAP_IDLE;
      kind_q        <= KIND_EXC;
      flush_q       <= 1'b0;
      stall_q       <= 1'b0;
      trap_we_q     <= 1'b0;
      mret_we_q     <= 1'b0;
      redirect_en_q <= 1'b0;
      irq_ack_q     <= 1'b0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      flush_q       <= flush_d;
      stall_q       <= stall_d;
      trap_we_q     <= trap_we_d;
      mret_we_q     <= mret_we_d;
      redirect_en_q <= redirect_en_d;
      irq_ack_q     <= irq_ack_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign flush        = flush_q;
  assign stall        = stall_q;
  assign trap_we      = trap_we_q;
  assign mret_we      = mret_we_q;
  assign redirect_en  = redirect_en_q;
  assign irq_ack      = irq_ack_q;
  assign mepc_wdata   = mepc_q;
  assign mcause_wdata = mcause_q;
  assign mtval_wdata  = mtval_q;
  assign redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a vector table of commit events with
// expected CSR-write and redirect values, a scoreboard queue of expected
// strobes, and hand-written sequences for masking, priority and reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid, commit_illegal, commit_ecall, commit_mret;
  logic [31:0] commit_pc, commit_inst;
  logic        irq_req, csr_mie;
  logic [31:0] csr_mtvec, csr_mepc;
  logic        flush, stall, trap_we, mret_we, redirect_en, irq_ack;
  logic [31:0] mepc_wdata, mcause_wdata, mtval_wdata, redirect_pc;

  trap_ctrl #(.XLEN(32), .IRQ_CODE(11)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .commit_inst    (commit_inst),
    .commit_illegal (commit_illegal),
    .commit_ecall   (commit_ecall),
    .commit_mret    (commit_mret),
    .irq_req        (irq_req),
    .csr_mie        (csr_mie),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
    .flush          (flush),
    .stall          (stall),
    .trap_we        (trap_we),
    .mepc_wdata     (mepc_wdata),
    .mcause_wdata   (mcause_wdata),
    .mtval_wdata    (mtval_wdata),
    .mret_we        (mret_we),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .irq_ack        (irq_ack)
  );

  always #5 clk = ~clk;

`ifdef TRAP_VECTORED_MTVEC_EN
  localparam logic [31:0] VEC_IRQ_RPC = 32'h0000_022C;
`else
  localparam logic [31:0] VEC_IRQ_RPC = 32'h0000_0200;
`endif
  localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

  typedef struct {
    logic        valid, illegal, ecall, mret, irq, mie;
    logic [31:0] pc, inst, mtvec, mepc;
    logic        evt;      // an event is expected
    logic        is_trap;  // 1: trap_we, 0: mret_we
    logic [31:0] mcause, mtval;
    logic        ack;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic        is_trap;
    logic [31:0] mepc, mcause, mtval;
    logic        ack;
    logic [31:0] rpc;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];
  exp_t cur;
  logic pending;
  logic mon_en;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Sample outputs on the falling edge and compare against the scoreboard
  task automatic monitor();
    if (trap_we || mret_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, trap_we, mret_we}, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        chk("trap_we", {31'd0, trap_we}, {31'd0, cur.is_trap});
        chk("mret_we", {31'd0, mret_we}, {31'd0, ~cur.is_trap});
        chk("csr_flush_stall", {30'd0, flush, stall}, 32'd3);
        chk("irq_ack", {31'd0, irq_ack}, {31'd0, cur.ack});
        if (cur.is_trap) begin
          chk("mepc_wdata", mepc_wdata, cur.mepc);
          chk("mcause_wdata", mcause_wdata, cur.mcause);
          chk("mtval_wdata", mtval_wdata, cur.mtval);
        end
        pending = 1'b1;
      end
    end else if (pending) begin
      chk("redirect_en", {31'd0, redirect_en}, 32'd1);
      chk("redirect_pc", redirect_pc, cur.rpc);
      chk("redir_flush_stall", {30'd0, flush, stall}, 32'd2);
      pending = 1'b0;
    end else begin
      chk("idle_outputs", {28'd0, flush, stall, redirect_en, irq_ack}, 32'd0);
    end
  endtask

  // One clock: check at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    commit_valid   = 1'b0;
    commit_illegal = 1'b0;
    commit_ecall   = 1'b0;
    commit_mret    = 1'b0;
    irq_req        = 1'b0;
  endtask

  task automatic push_exp(input logic is_trap, input logic [31:0] mepc, input logic [31:0] mcause,
                          input logic [31:0] mtval, input logic ack, input logic [31:0] rpc);
    exp_t e;
    e.is_trap = is_trap;
    e.mepc    = mepc;
    e.mcause  = mcause;
    e.mtval   = mtval;
    e.ack     = ack;
    e.rpc     = rpc;
    exp_q.push_back(e);
  endtask

  // Run until the scoreboard is empty; a stuck sequence counts as a failure
  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pending) && n < 12) begin
      tick();
      n++;
    end
    chk("drain_timeout", {31'd0, (exp_q.size() != 0 || pending)}, 32'd0);
    exp_q.delete();
    pending = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {26'd0, flush, stall, trap_we, mret_we, redirect_en, irq_ack}, 32'd0);
    chk({name, "_data"}, mepc_wdata | mcause_wdata | mtval_wdata | redirect_pc, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pending  = 1'b0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    clear_commit();
    commit_pc   = 32'd0;
    commit_inst = 32'd0;
    csr_mie     = 1'b0;
    csr_mtvec   = 32'd0;
    csr_mepc    = 32'd0;

    //           valid ill  ecall mret irq  mie  pc          inst          mtvec       mepc        evt  trap mcause      mtval         ack  rpc
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h100,32'hFFFF_FFFF,32'h200,32'h0,  1'b1,1'b1,32'd2,      32'hFFFF_FFFF,1'b0,32'h200};
    vecs[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h40, 32'h0000_0073,32'h203,32'h0,  1'b1,1'b1,32'd11,     32'h0,        1'b0,32'h200};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,32'h80, 32'h0000_0013,32'h300,32'h0,  1'b1,1'b1,IRQ_CAUSE,  32'h0,        1'b1,32'h300};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h60, 32'h3020_0073,32'h200,32'h104,1'b1,1'b0,32'h0,      32'h0,        1'b0,32'h104};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h64, 32'h3020_0073,32'h200,32'h107,1'b1,1'b0,32'h0,      32'h0,        1'b0,32'h104};
    vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h10C,32'h1234_5678,32'h400,32'h0,  1'b1,1'b1,32'd2,      32'h1234_5678,1'b0,32'h400};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h110,32'hDEAD_BEEF,32'h200,32'h0,  1'b1,1'b1,32'd2,      32'hDEAD_BEEF,1'b0,32'h200};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,32'h120,32'h0000_0013,32'h200,32'h0,  1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,32'h124,32'h0000_0013,32'h200,32'h0,  1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,32'h128,32'h3020_0073,32'h500,32'h104,1'b1,1'b1,IRQ_CAUSE,  32'h0,        1'b1,32'h500};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,32'h84, 32'h0000_0013,32'h201,32'h0,  1'b1,1'b1,IRQ_CAUSE,  32'h0,        1'b1,VEC_IRQ_RPC};
    vecs[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h88, 32'h0000_0073,32'h201,32'h0,  1'b1,1'b1,32'd11,     32'h0,        1'b0,32'h200};

    // Reset state
    #2;
    check_all_zero("reset_outputs");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick();
    tick();

    // Table-driven single events
    for (int i = 0; i < 12; i++) begin
      commit_valid   = vecs[i].valid;
      commit_illegal = vecs[i].illegal;
      commit_ecall   = vecs[i].ecall;
      commit_mret    = vecs[i].mret;
      irq_req        = vecs[i].irq;
      csr_mie        = vecs[i].mie;
      commit_pc      = vecs[i].pc;
      commit_inst    = vecs[i].inst;
      csr_mtvec      = vecs[i].mtvec;
      csr_mepc       = vecs[i].mepc;
      if (vecs[i].evt) begin
        push_exp(vecs[i].is_trap, vecs[i].pc, vecs[i].mcause, vecs[i].mtval, vecs[i].ack, vecs[i].rpc);
      end
      tick();
      clear_commit();
      wait_drain();
      tick();
      tick();
    end

    // Interrupt masked by MIE=0 for 10 committing cycles: no action
    irq_req      = 1'b1;
    csr_mie      = 1'b0;
    commit_valid = 1'b1;
    commit_pc    = 32'h90;
    repeat (10) tick();
    clear_commit();
    tick();

    // Illegal+irq: exception first, irq stays pending and is ignored mid-sequence,
    // waits while MIE=0, then is taken on the next valid commit with MIE=1
    csr_mtvec      = 32'h200;
    commit_valid   = 1'b1;
    commit_illegal = 1'b1;
    irq_req        = 1'b1;
    csr_mie        = 1'b1;
    commit_pc      = 32'h100;
    commit_inst    = 32'hFFFF_FFFF;
    push_exp(1'b1, 32'h100, 32'd2, 32'hFFFF_FFFF, 1'b0, 32'h200);
    tick();
    commit_illegal = 1'b0;
    commit_pc      = 32'h300;
    tick();
    tick();
    csr_mie = 1'b0;
    commit_pc = 32'h200;
    tick();
    tick();
    tick();
    chk("irq_wait_no_event", {31'd0, (exp_q.size() != 0 || pending)}, 32'd0);
    csr_mie = 1'b1;
    push_exp(1'b1, 32'h200, IRQ_CAUSE, 32'h0, 1'b1, 32'h200);
    tick();
    clear_commit();
    wait_drain();
    tick();

    // Asynchronous reset while in TRAP: outputs clear at once, no redirect after
    commit_valid   = 1'b1;
    commit_ecall   = 1'b1;
    commit_pc      = 32'h44;
    tick();
    clear_commit();
    chk("trap_before_reset", {31'd0, trap_we}, 32'd1);
    mon_en = 1'b0;
    exp_q.delete();
    pending = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    @(negedge clk);
    check_all_zero("reset_held_outputs");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequential trap responder for the pipelined RV32I core.
- Consumes the exception request raised by instruction decode (illegal-instruction flag), plus ecall/mret indications and an external interrupt request, all sampled at the commit point (MEM stage).
- Sequences the pipeline flush, machine-CSR trap writes (mepc/mcause/mtval, MIE/MPIE) and the PC redirect to mtvec or mepc.

Parameters:
- XLEN, 32, datapath width.
- IRQ_CODE, 11, mcause exception code for the external interrupt (machine external interrupt).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- commit_valid  input  1  a real (non-bubble) instruction is at the commit point this cycle.
- commit_pc  input  XLEN  PC of the committing instruction.
- commit_inst  input  32  raw instruction word of the committing instruction.
- commit_illegal  input  1  decode flagged the instruction as invalid.
- commit_ecall  input  1  instruction is ecall.
- commit_mret  input  1  instruction is mret.
- irq_req  input  1  level interrupt request; held until acknowledged.
- csr_mie  input  1  mstatus.MIE.
- csr_mtvec  input  XLEN  current mtvec.
- csr_mepc  input  XLEN  current mepc.
- flush  output  1  kill IF/ID/EX/MEM contents; blocks RF, RAM and CSR writes.
- stall  output  1  freeze PC and fetch while a trap is in progress.
- trap_we  output  1  one-cycle strobe: write mepc/mcause/mtval, set MPIE=MIE, clear MIE.
- mepc_wdata  output  XLEN  value written to mepc.
- mcause_wdata  output  XLEN  value written to mcause.
- mtval_wdata  output  XLEN  value written to mtval.
- mret_we  output  1  one-cycle strobe: set MIE=MPIE, MPIE=1.
- redirect_en  output  1  one-cycle strobe: load PC from redirect_pc.
- redirect_pc  output  XLEN  new fetch address.
- irq_ack  output  1  one-cycle acknowledge of irq_req.

Behaviour:
- Reset: every output is 0; the state is IDLE. Asserting rst_n low in any state returns the block to IDLE immediately, with no strobe issued.
- States: IDLE, TRAP, MRET, REDIRECT.
- IDLE, event selection at cycle N. Only commit_valid=1 qualifies an event. Priority is:
  - commit_illegal, then commit_ecall (synchronous exceptions);
  - then irq_req&&csr_mie (interrupt taken on the committing instruction);
  - then commit_mret.
- IDLE, latching at cycle N: the winning event is captured in registers, holding pc, cause, tval and kind. Next state is TRAP for an exception or interrupt, and MRET for mret.
- IDLE, no event: flush=0, stall=0 and the state remains IDLE.
- TRAP (cycle N+1):
  - flush=1, stall=1, trap_we=1.
  - mepc_wdata: the latched PC for an exception or interrupt. The instruction is not retired and its RF/RAM writes are suppressed by flush.
  - mcause_wdata: 2 for illegal, 11 for ecall, {1'b1, IRQ_CODE zero-extended} for interrupt.
  - mtval_wdata: commit_inst for illegal, 0 otherwise.
  - irq_ack=1 only for the interrupt kind.
  - Next state is REDIRECT.
- MRET (cycle N+1): flush=1, stall=1, mret_we=1. Next state is REDIRECT. The target is csr_mepc, sampled in this cycle.
- REDIRECT (cycle N+2):
  - redirect_en=1, flush=1, stall=0. Next state is IDLE.
  - Trap target: {csr_mtvec[XLEN-1:2], 2'b00}.
  - MRET target: {csr_mepc[XLEN-1:2], 2'b00}.
- Total latency: 2 cycles from the committing event to redirect.
- All inputs are ignored outside IDLE. No nested trap is possible; an irq arriving mid-sequence waits.
- The first instruction fetched from the target can be interrupted again only after it reaches commit with MIE=1. Because MIE is cleared on trap entry, back-to-back interrupt entry cannot occur.
- Simultaneous illegal+irq: the exception is taken and irq_ack is not asserted; irq_req stays pending.
- commit_valid=0 with irq pending: no action. The interrupt waits for a valid commit so that mepc is always a real PC.

Optional Feature:
- Macro: TRAP_VECTORED_MTVEC_EN.
- Defined: if csr_mtvec[1:0]==2'b01 and the kind is interrupt, the redirect target is base + (cause_code<<2), i.e. base+0x2C for IRQ_CODE=11. Exceptions always go to base.
- Undefined: the mode bits are ignored and every trap goes to base.

Decomposition:
- defines.v additions:
  - Cause codes CAUSE_ILLEGAL=2, CAUSE_ECALL_M=11.
  - Interrupt bit position.
  - State encodings TRAP_IDLE/TRAP_TRAP/TRAP_MRET/TRAP_REDIR and TRAP_ST_WIDTH=2.
  - Kind encodings KIND_EXC/KIND_IRQ/KIND_MRET.
- One combinational sub-module, trap_cause_enc, selects the winning event and produces kind, cause and tval. The FSM, latches and target mux stay in trap_ctrl.

Test Plan:
- Illegal: commit_valid=1, commit_illegal=1, pc=0x100, inst=0xFFFFFFFF, mtvec=0x200. Required: at N+1 trap_we with mepc=0x100, mcause=2, mtval=0xFFFFFFFF, flush=1; at N+2 redirect_en with pc=0x200; then IDLE.
- Ecall: pc=0x40. Required: mcause=11, mtval=0, redirect to the mtvec base with the low 2 bits cleared (mtvec=0x203 -> 0x200).
- Interrupt: irq_req=1, csr_mie=1, pc=0x80. Required: irq_ack at N+1, mcause=0x8000000B, mepc=0x80. With csr_mie=0, no action for 10 cycles.
- Priority and masking:
  - illegal+irq together: exception taken, irq_ack=0, irq taken on the next valid commit once MIE=1.
  - irq with commit_valid=0: no action.
- Mret: csr_mepc=0x104. Required: mret_we at N+1, redirect_pc=0x104 at N+2, and no trap_we.
- Reset mid-sequence: rst_n low during TRAP. Required: all outputs 0 asynchronously and no redirect after release. With TRAP_VECTORED_MTVEC_EN and mtvec=0x201, an interrupt redirects to 0x22C.
